// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - word-organised data RAM answering one load/store at a time after a fixed latency
module dmem_responder #(
    parameter int          DATA_WIDTH = 32,
    parameter int          DEPTH      = 1024,
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter int          LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wen,
    input  logic [DATA_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [7:0]            req_wmask,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                  state;
    logic [3:0]              cnt;
    logic                    l_wen;
    logic [DATA_WIDTH-1:0]   l_addr;
    logic [DATA_WIDTH-1:0]   l_wdata;
    logic [3:0]              l_mask;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    a_wen;
    logic [DATA_WIDTH-1:0]   a_addr;
    logic [DATA_WIDTH-1:0]   a_wdata;
    logic [3:0]              a_mask;
    logic [DATA_WIDTH-1:0]   off;
    logic [1:0]              bofs;
    logic [AW-1:0]           mem_idx;
    logic                    range_err;
    logic                    align_err;
    logic                    acc_err;
    logic [7:0]              lane_wide;
    logic [3:0]              lanes;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic [DATA_WIDTH-1:0]   rd_data;
    logic [DATA_WIDTH-1:0]   acc_rdata;
    logic                    enter_resp;
    logic                    unused_bits;

    // With LATENCY==1 the access happens on the accepting edge, so the live request is used in IDLE.
    always_comb begin
        if (state == IDLE) begin
            a_wen   = req_wen;
            a_addr  = req_addr;
            a_wdata = req_wdata;
            a_mask  = req_wmask[3:0];
        end else begin
            a_wen   = l_wen;
            a_addr  = l_addr;
            a_wdata = l_wdata;
            a_mask  = l_mask;
        end
    end

    assign off       = a_addr - BASE_ADDR;
    assign bofs      = a_addr[1:0];
    assign mem_idx   = off[AW+1:2];
    assign range_err = {2'b00, off[DATA_WIDTH-1:2]} >= 32'(DEPTH);

    always_comb begin
        case (a_mask)
            4'b0001: align_err = 1'b0;
            4'b0011: align_err = bofs[0];
            4'b1111: align_err = |bofs;
            default: align_err = 1'b1;
        endcase
    end

    assign acc_err    = range_err || (a_wen && align_err);
    assign lane_wide  = {4'b0000, a_mask} << bofs;
    assign lanes      = lane_wide[3:0];
    assign wr_data    = a_wdata << {bofs, 3'b000};
    assign rd_data    = mem[mem_idx] >> {bofs, 3'b000};
    assign acc_rdata  = (a_wen || acc_err) ? '0 : rd_data;
    assign enter_resp = rst_n && (((state == IDLE) && req_valid && (LATENCY == 1)) ||
                                  ((state == WAIT) && (cnt == 4'd0)));
    assign unused_bits = ^{req_wmask[7:4], lane_wide[7:4], off[1:0]};

    always_ff @(posedge clk) begin
        if (enter_resp && a_wen && !acc_err) begin
            for (int k = 0; k < 4; k++) begin
                if (lanes[k]) mem[mem_idx][8*k +: 8] <= wr_data[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            cnt        <= 4'd0;
            l_wen      <= 1'b0;
            l_addr     <= '0;
            l_wdata    <= '0;
            l_mask     <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        l_wen     <= req_wen;
                        l_addr    <= req_addr;
                        l_wdata   <= req_wdata;
                        l_mask    <= req_wmask[3:0];
                        req_ready <= 1'b0;
                        if (LATENCY == 1) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_rdata <= acc_rdata;
                            resp_err   <= acc_err;
                        end else begin
                            state <= WAIT;
                            cnt   <= 4'(LATENCY - 2);
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= acc_rdata;
                        resp_err   <= acc_err;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        resp_err   <= 1'b0;
                        req_ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder at latencies 2, 1 and 7
module tb_dmem_responder;
    localparam logic [31:0] BASE = 32'h8000_0000;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [2:0]       req_valid_v = '0;
    logic [2:0]       req_ready_v;
    logic [2:0]       req_wen_v = '0;
    logic [2:0][31:0] req_addr_a = '0;
    logic [2:0][31:0] req_wdata_a = '0;
    logic [2:0][7:0]  req_wmask_a = '0;
    logic [2:0]       resp_valid_v;
    logic [2:0]       resp_ready_v = '0;
    logic [2:0][31:0] resp_rdata_a;
    logic [2:0]       resp_err_v;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    // Instance 0: LATENCY=2, instance 1: LATENCY=1, instance 2: LATENCY=7
    for (genvar g = 0; g < 3; g++) begin : g_dut
        dmem_responder #(
            .LATENCY((g == 0) ? 2 : ((g == 1) ? 1 : 7))
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .req_valid  (req_valid_v[g]),
            .req_ready  (req_ready_v[g]),
            .req_wen    (req_wen_v[g]),
            .req_addr   (req_addr_a[g]),
            .req_wdata  (req_wdata_a[g]),
            .req_wmask  (req_wmask_a[g]),
            .resp_valid (resp_valid_v[g]),
            .resp_ready (resp_ready_v[g]),
            .resp_rdata (resp_rdata_a[g]),
            .resp_err   (resp_err_v[g])
        );
    end

    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : ((d == 1) ? 1 : 7);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic req(input int d, input string tag, input bit wen, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [7:0] mask,
                       input logic [31:0] exp_rdata, input logic exp_err, input int hold);
        exp_t e;
        int   n;
        sb.push_back('{rdata: exp_rdata, err: exp_err});
        n = 0;
        while (!req_ready_v[d] && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk({tag, "_ready"}, 32'(req_ready_v[d]), 32'd1);
        req_wen_v[d]   = wen;
        req_addr_a[d]  = addr;
        req_wdata_a[d] = wdata;
        req_wmask_a[d] = mask;
        req_valid_v[d] = 1'b1;
        @(posedge clk); #1;
        req_valid_v[d] = 1'b0;
        req_wen_v[d]   = ~wen;
        req_addr_a[d]  = $urandom;
        req_wdata_a[d] = $urandom;
        req_wmask_a[d] = 8'($urandom);
        n = 1;
        while (!resp_valid_v[d] && n < 40) begin
            @(posedge clk); #1; n++;
        end
        chk({tag, "_lat"}, 32'(n), 32'(lat_of(d)));
        e = sb.pop_front();
        chk({tag, "_rdata"}, resp_rdata_a[d], e.rdata);
        chk({tag, "_err"}, 32'(resp_err_v[d]), 32'(e.err));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, "_hold_valid"}, 32'(resp_valid_v[d]), 32'd1);
            chk({tag, "_hold_rdata"}, resp_rdata_a[d], e.rdata);
            chk({tag, "_hold_err"}, 32'(resp_err_v[d]), 32'(e.err));
            chk({tag, "_hold_ready"}, 32'(req_ready_v[d]), 32'd0);
        end
        resp_ready_v[d] = 1'b1;
        @(posedge clk); #1;
        resp_ready_v[d] = 1'b0;
        chk({tag, "_done_valid"}, 32'(resp_valid_v[d]), 32'd0);
        chk({tag, "_done_ready"}, 32'(req_ready_v[d]), 32'd1);
        chk({tag, "_done_err"}, 32'(resp_err_v[d]), 32'd0);
        chk({tag, "_done_rdata"}, resp_rdata_a[d], e.rdata);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready_v[0]), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid_v[0]), 32'd0);
        chk("rst_resp_rdata", resp_rdata_a[0], 32'd0);
        chk("rst_resp_err", 32'(resp_err_v[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        req(0, "st_word", 1'b1, BASE + 32'h10, 32'hDEAD_BEEF, 8'h0F, 32'h0, 1'b0, 0);
        req(0, "ld_word", 1'b0, BASE + 32'h10, 32'h0, 8'h0F, 32'hDEAD_BEEF, 1'b0, 0);
        req(0, "st_clear", 1'b1, BASE + 32'h10, 32'h0, 8'h0F, 32'h0, 1'b0, 0);
        req(0, "st_byte", 1'b1, BASE + 32'h13, 32'h0000_00AA, 8'h01, 32'h0, 1'b0, 0);
        req(0, "st_half", 1'b1, BASE + 32'h10, 32'h0000_1234, 8'h03, 32'h0, 1'b0, 0);
        req(0, "ld_mix_bp", 1'b0, BASE + 32'h10, 32'h0, 8'h0F, 32'hAA00_1234, 1'b0, 5);
        req(0, "ld_off3", 1'b0, BASE + 32'h13, 32'h0, 8'h0F, 32'h0000_00AA, 1'b0, 0);
        req(0, "st_byte_hi_mask", 1'b1, BASE + 32'h11, 32'h0000_0055, 8'hF1, 32'h0, 1'b0, 0);
        req(0, "ld_after_byte", 1'b0, BASE + 32'h10, 32'h0, 8'h0F, 32'hAA00_5534, 1'b0, 0);

        req(0, "st_w0", 1'b1, BASE, 32'h1122_3344, 8'h0F, 32'h0, 1'b0, 0);
        req(0, "st_misalign", 1'b1, BASE + 32'h2, 32'hFFFF_FFFF, 8'h0F, 32'h0, 1'b1, 0);
        req(0, "ld_w0_kept", 1'b0, BASE, 32'h0, 8'h0F, 32'h1122_3344, 1'b0, 0);
        req(0, "ld_below", 1'b0, 32'h7FFF_FFFC, 32'h0, 8'h0F, 32'h0, 1'b1, 0);
        req(0, "ld_above", 1'b0, BASE + 32'h1000, 32'h0, 8'h0F, 32'h0, 1'b1, 0);
        req(0, "st_mask7", 1'b1, BASE + 32'h10, 32'hFFFF_FFFF, 8'h07, 32'h0, 1'b1, 0);
        req(0, "ld_mask7_kept", 1'b0, BASE + 32'h10, 32'h0, 8'h0F, 32'hAA00_5534, 1'b0, 0);

        req(0, "st_pre_rst", 1'b1, BASE + 32'h20, 32'hCAFE_F00D, 8'h0F, 32'h0, 1'b0, 0);
        req(0, "ld_pre_rst", 1'b0, BASE + 32'h20, 32'h0, 8'h0F, 32'hCAFE_F00D, 1'b0, 0);
        req_wen_v[0]   = 1'b1;
        req_addr_a[0]  = BASE + 32'h20;
        req_wdata_a[0] = 32'h1234_5678;
        req_wmask_a[0] = 8'h0F;
        req_valid_v[0] = 1'b1;
        @(posedge clk); #1;
        req_valid_v[0] = 1'b0;
        chk("mid_busy", 32'(req_ready_v[0]), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req_ready", 32'(req_ready_v[0]), 32'd1);
        chk("mid_rst_resp_valid", 32'(resp_valid_v[0]), 32'd0);
        chk("mid_rst_resp_rdata", resp_rdata_a[0], 32'd0);
        chk("mid_rst_resp_err", 32'(resp_err_v[0]), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        req(0, "ld_post_rst", 1'b0, BASE + 32'h20, 32'h0, 8'h0F, 32'hCAFE_F00D, 1'b0, 0);

        req(1, "l1_st", 1'b1, BASE + 32'h4, 32'h0BAD_CAFE, 8'h0F, 32'h0, 1'b0, 0);
        req(1, "l1_ld", 1'b0, BASE + 32'h6, 32'h0, 8'h0F, 32'h0000_0BAD, 1'b0, 2);
        req(2, "l7_st", 1'b1, BASE + 32'h4, 32'h5A5A_A5A5, 8'h0F, 32'h0, 1'b0, 0);
        req(2, "l7_ld", 1'b0, BASE + 32'h4, 32'h0, 8'h0F, 32'h5A5A_A5A5, 1'b0, 2);
        req(2, "l7_err", 1'b0, BASE + 32'h1000, 32'h0, 8'h0F, 32'h0, 1'b1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
